// File: rtl/arf104b256e1r1w0cbbehcaa4acw_bcam_mbist_pkg.sv
// Shared types for the BCAM MBIST fail-capture block: FSM state encoding and
// the reference-select codes carried with each compare strobe.
package arf104b256e1r1w0cbbehcaa4acw_bcam_mbist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FAIL = 2'b10,
    ST_SAT  = 2'b11
  } cm_state_e;

  localparam logic [1:0] SEL_ALL_MATCH       = 2'b00;
  localparam logic [1:0] SEL_SINGLE_MATCH    = 2'b01;
  localparam logic [1:0] SEL_SINGLE_MISMATCH = 2'b10;
  localparam logic [1:0] SEL_ALL_MISMATCH    = 2'b11;

endpackage

// File: rtl/arf104b256e1r1w0cbbehcaa4acw_bcam_mbist_align_pipe.sv
// Two-stage delay line that lines strobe/address up with the out-handler's
// compare data; flush empties both stages so no stale strobe survives a clear.
module arf104b256e1r1w0cbbehcaa4acw_bcam_mbist_align_pipe #(
  parameter int W = 1
) (
  input  logic         bist_clk,
  input  logic         bist_rst,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage1;

  always_ff @(posedge bist_clk or posedge bist_rst) begin
    if (bist_rst) begin
      stage1 <= '0;
      q      <= '0;
    end else if (flush) begin
      stage1 <= '0;
      q      <= '0;
    end else begin
      stage1 <= d;
      q      <= stage1;
    end
  end

endmodule

// File: rtl/blk_d7afa3.sv
// BCAM MBIST fail capture: aligns compare strobes with the compacted mismatch
// vectors, flags fails, records the first failing entry and counts fails.
module blk_d7afa3
  import arf104b256e1r1w0cbbehcaa4acw_bcam_mbist_pkg::*;
#(
  parameter int RF_ENTRIES = 128,
  parameter int RF_DWIDTH  = 72,
  parameter int RF_AWIDTH  = 7,
  parameter int RD_PORTS   = 1,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                          bist_clk,
  input  logic                          bist_rst,
  input  logic                          BIST_CM_MODE_RF_IN,
  input  logic                          BIST_CMP_EN_RF_IN,
  input  logic [1:0]                    BIST_CM_MATCH_SEL_RF_IN,
  input  logic [RF_AWIDTH-1:0]          BIST_RD_ADDR_RF_IN_P0,
  input  logic                          BIST_CLR_RF_IN,
  input  logic [RF_DWIDTH*RD_PORTS-1:0] RD_DATA_RF_OUT,
  output logic                          CM_FAIL_PULSE,
  output logic                          CM_FAIL_STICKY,
  output logic [RF_AWIDTH-1:0]          CM_FIRST_FAIL_ADDR,
  output logic [RF_DWIDTH-1:0]          CM_FIRST_FAIL_VEC,
  output logic [1:0]                    CM_FIRST_FAIL_SEL,
  output logic [CNT_WIDTH-1:0]          CM_FAIL_CNT,
  output logic [1:0]                    CM_STATE
);

  localparam int PW = 4 + RF_AWIDTH;
  localparam int unsigned ENTRIES = RF_ENTRIES;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_PRE = ~(CNT_WIDTH'(1));

  logic [PW-1:0]        pipe_d;
  logic [PW-1:0]        pipe_q;
  logic                 en_2d;
  logic                 mode_2d;
  logic [1:0]           sel_2d;
  logic [RF_AWIDTH-1:0] addr_2d;
  logic [RF_DWIDTH-1:0] merged_vec;
  logic                 addr_ok;
  logic                 err;
  logic                 near_max;
  cm_state_e            state;

  assign pipe_d = {BIST_CMP_EN_RF_IN, BIST_CM_MODE_RF_IN, BIST_CM_MATCH_SEL_RF_IN,
                   BIST_RD_ADDR_RF_IN_P0};
  assign {en_2d, mode_2d, sel_2d, addr_2d} = pipe_q;

  arf104b256e1r1w0cbbehcaa4acw_bcam_mbist_align_pipe #(.W(PW)) u_align (
    .bist_clk (bist_clk),
    .bist_rst (bist_rst),
    .flush    (BIST_CLR_RF_IN),
    .d        (pipe_d),
    .q        (pipe_q)
  );

  always_comb begin
    merged_vec = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      merged_vec = merged_vec | RD_DATA_RF_OUT[p*RF_DWIDTH +: RF_DWIDTH];
    end
  end

  // Addresses beyond the populated entries have no CAM row behind them.
  assign addr_ok  = (32'(addr_2d) < ENTRIES);
  assign err      = en_2d & mode_2d & addr_ok & (|merged_vec);
  assign near_max = (CM_FAIL_CNT == CNT_PRE);
  assign CM_STATE = state;

  always_ff @(posedge bist_clk or posedge bist_rst) begin
    if (bist_rst) begin
      CM_FAIL_PULSE      <= 1'b0;
      CM_FAIL_STICKY     <= 1'b0;
      CM_FIRST_FAIL_ADDR <= '0;
      CM_FIRST_FAIL_VEC  <= '0;
      CM_FIRST_FAIL_SEL  <= 2'b00;
      CM_FAIL_CNT        <= '0;
      state              <= ST_IDLE;
    end else if (BIST_CLR_RF_IN) begin
      CM_FAIL_PULSE      <= 1'b0;
      CM_FAIL_STICKY     <= 1'b0;
      CM_FIRST_FAIL_ADDR <= '0;
      CM_FIRST_FAIL_VEC  <= '0;
      CM_FIRST_FAIL_SEL  <= 2'b00;
      CM_FAIL_CNT        <= '0;
      state              <= ST_IDLE;
    end else begin
      CM_FAIL_PULSE <= err;
      if (err) begin
        CM_FAIL_STICKY <= 1'b1;
        if (!CM_FAIL_STICKY) begin
          CM_FIRST_FAIL_ADDR <= addr_2d;
          CM_FIRST_FAIL_VEC  <= merged_vec;
          CM_FIRST_FAIL_SEL  <= sel_2d;
        end
        if (CM_FAIL_CNT != CNT_MAX) CM_FAIL_CNT <= CM_FAIL_CNT + CNT_WIDTH'(1);
      end
      case (state)
        ST_IDLE: begin
          if (err)        state <= near_max ? ST_SAT : ST_FAIL;
          else if (en_2d) state <= ST_RUN;
        end
        ST_RUN:  if (err) state <= near_max ? ST_SAT : ST_FAIL;
        ST_FAIL: if (err && near_max) state <= ST_SAT;
        ST_SAT:  state <= ST_SAT;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
